// File: rtl/fastserial_device_pkg.sv
// Shared constants and state encodings for the fastserial device slice.
package fastserial_device_pkg;

    localparam int FS_DATA_BITS   = 8;
    localparam int FS_FRAME_BITS  = 10;
    localparam int FS_MIN_DIVIDER = 4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_SRC  = 2'd2
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE  = 3'd0,
        T_WAIT  = 3'd1,
        T_START = 3'd2,
        T_DATA  = 3'd3,
        T_SRC   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/fastserial_device_if.sv
// Serial pins plus the byte-level RX/TX handshakes of the fastserial device.
interface fastserial_device_if;
    logic       i_fsclk;
    logic       i_fsdi;
    logic       o_fsdo;
    logic       o_fscts;
    logic [7:0] o_rx_data;
    logic       o_rx_src;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic       o_rx_overrun;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;

    modport slave (
        input  i_fsclk, i_fsdi, i_rx_ready, i_tx_data, i_tx_valid,
        output o_fsdo, o_fscts, o_rx_data, o_rx_src, o_rx_valid, o_rx_overrun, o_tx_ready
    );

    modport master (
        output i_fsclk, i_fsdi, i_rx_ready, i_tx_data, i_tx_valid,
        input  o_fsdo, o_fscts, o_rx_data, o_rx_src, o_rx_valid, o_rx_overrun, o_tx_ready
    );
endinterface

// File: rtl/fs_byte_fifo.sv
// First-word-fall-through FIFO holding {src, byte} entries with a registered count.
module fs_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push while full fails even if a pop happens in the same cycle.
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign count     = count_r;
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/fastserial_device.sv
// Fastserial device endpoint: synchronised serial RX into a byte FIFO and an
// independent serial TX, both clocked by edges of the host-driven fsclk.
module fastserial_device
    import fastserial_device_pkg::*;
#(
    parameter int   RX_DEPTH = 4,
    parameter logic TX_SRC   = 1'b0
) (
    input logic                wb_clk,
    input logic                wb_rst,
    fastserial_device_if.slave fs
);
    localparam int AW = $clog2(RX_DEPTH);

    logic                    fsclk_s1_r, fsclk_s2_r, fsclk_s3_r;
    logic                    fsdi_s1_r, fsdi_s2_r;
    logic                    fs_rise_s, fs_fall_s;
    rx_state_t               rx_state_r;
    logic [2:0]              rx_cnt_r;
    logic [FS_DATA_BITS-1:0] rx_shift_r;
    logic                    rx_push_s, rx_pop_s, rx_busy_s;
    logic [FS_DATA_BITS:0]   rx_head_s;
    logic [AW:0]             rx_count_s, rx_cts_sum_s;
    logic                    rx_full_s, rx_empty_s;
    logic                    overrun_r, fscts_r;
    tx_state_t               tx_state_r;
    logic [3:0]              tx_cnt_r;
    logic [FS_DATA_BITS-1:0] tx_shift_r;
    logic                    fsdo_r, tx_ready_r;

    // Two-flop synchronisers of equal depth keep fsdi aligned with the fsclk edge.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            fsclk_s1_r <= 1'b0;
            fsclk_s2_r <= 1'b0;
            fsclk_s3_r <= 1'b0;
            fsdi_s1_r  <= 1'b0;
            fsdi_s2_r  <= 1'b0;
        end else begin
            fsclk_s1_r <= fs.i_fsclk;
            fsclk_s2_r <= fsclk_s1_r;
            fsclk_s3_r <= fsclk_s2_r;
            fsdi_s1_r  <= fs.i_fsdi;
            fsdi_s2_r  <= fsdi_s1_r;
        end
    end

    assign fs_rise_s = fsclk_s2_r & ~fsclk_s3_r;
    assign fs_fall_s = ~fsclk_s2_r & fsclk_s3_r;
    assign rx_push_s = (rx_state_r == R_SRC) & fs_rise_s;
    assign rx_busy_s = (rx_state_r != R_IDLE);
    assign rx_pop_s  = fs.i_rx_ready & ~rx_empty_s;

    // RX frame FSM: start bit, eight data bits LSB first, then the source bit.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rx_state_r <= R_IDLE;
            rx_cnt_r   <= 3'd0;
            rx_shift_r <= {FS_DATA_BITS{1'b0}};
        end else begin
            case (rx_state_r)
                R_IDLE: begin
                    if (fs_rise_s && !fsdi_s2_r) begin
                        rx_state_r <= R_DATA;
                        rx_cnt_r   <= 3'd0;
                    end
                end
                R_DATA: begin
                    if (fs_rise_s) begin
                        rx_shift_r <= {fsdi_s2_r, rx_shift_r[FS_DATA_BITS-1:1]};
                        rx_cnt_r   <= rx_cnt_r + 3'd1;
                        if (rx_cnt_r == 3'd7) begin
                            rx_state_r <= R_SRC;
                        end
                    end
                end
                R_SRC: begin
                    if (fs_rise_s) begin
                        rx_state_r <= R_IDLE;
                    end
                end
                default: rx_state_r <= R_IDLE;
            endcase
        end
    end

    fs_byte_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (FS_DATA_BITS + 1)
    ) u_fifo (
        .clk       (wb_clk),
        .rst       (wb_rst),
        .push      (rx_push_s),
        .push_data ({fsdi_s2_r, rx_shift_r}),
        .pop       (rx_pop_s),
        .head      (rx_head_s),
        .count     (rx_count_s),
        .full      (rx_full_s),
        .empty     (rx_empty_s)
    );

    // A frame in flight reserves a slot, so CTS drops as soon as it starts.
    assign rx_cts_sum_s = rx_count_s + {{AW{1'b0}}, rx_busy_s};

    // Registered RX status flags.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            overrun_r <= 1'b0;
            fscts_r   <= 1'b0;
        end else begin
            overrun_r <= rx_push_s & rx_full_s;
            fscts_r   <= (rx_cts_sum_s < (AW+1)'(RX_DEPTH));
        end
    end

    // TX frame FSM: each detected fall emits the next bit; ready only when idle.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            tx_state_r <= T_IDLE;
            tx_cnt_r   <= 4'd0;
            tx_shift_r <= {FS_DATA_BITS{1'b0}};
            fsdo_r     <= 1'b1;
            tx_ready_r <= 1'b0;
        end else begin
            case (tx_state_r)
                T_IDLE: begin
                    fsdo_r <= 1'b1;
                    if (fs.i_tx_valid && tx_ready_r) begin
                        tx_shift_r <= fs.i_tx_data;
                        tx_state_r <= T_WAIT;
                        tx_ready_r <= 1'b0;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                T_WAIT: begin
                    if (fs_fall_s) begin
                        fsdo_r     <= 1'b0;
                        tx_state_r <= T_START;
                    end
                end
                T_START: begin
                    if (fs_fall_s) begin
                        fsdo_r     <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[FS_DATA_BITS-1:1]};
                        tx_cnt_r   <= 4'd1;
                        tx_state_r <= T_DATA;
                    end
                end
                T_DATA: begin
                    if (fs_fall_s) begin
                        if (tx_cnt_r == 4'd8) begin
                            fsdo_r     <= TX_SRC;
                            tx_state_r <= T_SRC;
                        end else begin
                            fsdo_r     <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[FS_DATA_BITS-1:1]};
                            tx_cnt_r   <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                T_SRC: begin
                    if (fs_fall_s) begin
                        fsdo_r     <= 1'b1;
                        tx_state_r <= T_IDLE;
                        tx_ready_r <= 1'b1;
                    end
                end
                default: begin
                    fsdo_r     <= 1'b1;
                    tx_state_r <= T_IDLE;
                    tx_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign fs.o_fsdo       = fsdo_r;
    assign fs.o_fscts      = fscts_r;
    assign fs.o_rx_data    = rx_head_s[FS_DATA_BITS-1:0];
    assign fs.o_rx_src     = rx_head_s[FS_DATA_BITS];
    assign fs.o_rx_valid   = ~rx_empty_s;
    assign fs.o_rx_overrun = overrun_r;
    assign fs.o_tx_ready   = tx_ready_r;
endmodule

// File: doc/fastserial_device.md
FASTSERIAL_DEVICE -- requirements
Module: fastserial_device

Interface
REQ-001 Parameter RX_DEPTH, default 4: RX FIFO depth in bytes, power of two, 2..16.
REQ-002 Parameter TX_SRC, default 0: value sent in the source bit of every TX frame.
REQ-003 wb_clk  in  1  single clock; all logic is on the rising edge.
REQ-004 wb_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_fsclk  in  1  serial clock driven by the host (fastserial_wb); asynchronous to wb_clk.
REQ-006 i_fsdi  in  1  serial data from the host; valid at rising edges of i_fsclk.
REQ-007 o_fsdo  out  1  serial data to the host; idles high.
REQ-008 o_fscts  out  1  clear-to-send; high means the block can accept one more frame.
REQ-009 o_rx_data  out  8  received byte at the FIFO head.
REQ-010 o_rx_src  out  1  source bit of the byte at the FIFO head.
REQ-011 o_rx_valid  out  1  FIFO is non-empty.
REQ-012 i_rx_ready  in  1  consumer pops the head when o_rx_valid && i_rx_ready.
REQ-013 o_rx_overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
REQ-014 i_tx_data  in  8  byte to transmit.
REQ-015 i_tx_valid  in  1  TX request.
REQ-016 o_tx_ready  out  1  transmitter idle; a byte is accepted when i_tx_valid && o_tx_ready.

Function
REQ-017 i_fsclk and i_fsdi SHALL each pass through a 2-flop synchronizer of equal depth; edges are detected against a third flop (rise = s2 & ~s3, fall = ~s2 & s3).
REQ-018 The block SHALL operate correctly when each i_fsclk high and low phase lasts at least 2 wb_clk periods (host divider >= 4).
REQ-019 The RX FSM SHALL have states R_IDLE, R_DATA and R_SRC; in R_IDLE a rise with synced fsdi=0 is a start bit and moves the FSM to R_DATA.
REQ-020 R_DATA SHALL shift 8 bits on 8 consecutive rises, LSB first, then move to R_SRC.
REQ-021 R_SRC SHALL capture the source bit on the next rise, push {src, byte} into the FIFO on the same cycle and return to R_IDLE.
REQ-022 Latency: o_rx_valid SHALL be high 1 wb_clk after the push cycle when the FIFO was empty.
REQ-023 A push to a full FIFO SHALL drop the frame, leave the FIFO unchanged and pulse o_rx_overrun.
REQ-024 A simultaneous push and pop on a full FIFO SHALL be a push-fail; a simultaneous push and pop on a non-full FIFO SHALL both complete, with the count unchanged.
REQ-025 o_fscts SHALL be registered and equal (count + (rx_state != R_IDLE)) < RX_DEPTH.
REQ-026 The TX FSM SHALL have states T_IDLE, T_WAIT, T_START, T_DATA and T_SRC; o_tx_ready is high only in T_IDLE.
REQ-027 Accepting a byte SHALL latch it and move the FSM to T_WAIT, with o_fsdo held at 1.
REQ-028 Each subsequent fall SHALL advance the TX FSM and update a registered o_fsdo: T_START drives 0, T_DATA drives 8 bits LSB first, T_SRC drives TX_SRC.
REQ-029 The fall after T_SRC SHALL drive o_fsdo to 1 and return the FSM to T_IDLE; a frame is 10 bits over 11 falls including the idle return.
REQ-030 i_tx_valid outside T_IDLE SHALL be ignored; i_tx_data is sampled only on acceptance.
REQ-031 RX and TX SHALL be fully independent and run concurrently.

Reset
REQ-032 Assertion of wb_rst SHALL immediately force R_IDLE, T_IDLE, an empty FIFO, cleared synchronizers, o_fsdo=1 and o_fscts=0.
REQ-033 During reset o_rx_valid=0, o_rx_overrun=0, o_tx_ready=0, o_rx_data=0 and o_rx_src=0.
REQ-034 o_tx_ready and o_fscts SHALL rise on the first wb_clk edge after reset release.
REQ-035 A frame interrupted by reset SHALL be discarded; no partial byte may ever be pushed or sent.

Structure
REQ-036 A shared package SHALL hold FS_DATA_BITS=8, FS_FRAME_BITS=10, the RX and TX state encodings, and FS_MIN_DIVIDER=4.
REQ-037 The FIFO SHALL be one sub-module, fs_byte_fifo: 9-bit wide, RX_DEPTH deep, with registered count and first-word-fall-through output.

Verification
REQ-038 Host sends 0xA5 with src=0 at divider 8 -> o_rx_data=0xA5, o_rx_src=0, o_rx_valid high; bits observed 0,1,0,1,0,0,1,0,1.
REQ-039 i_tx_data=0x3C accepted with TX_SRC=0 -> o_fsdo across falls is 0,0,0,1,1,1,1,0,0,0,1 and o_tx_ready returns high.
REQ-040 With i_rx_ready=0, host sends 4 bytes -> o_fscts low after the start of the 4th frame; a forced 5th frame produces one o_rx_overrun pulse and the FIFO holds the first 4 bytes.
REQ-041 Concurrent RX of 0x55 and TX of 0xAA at divider 4 -> both bytes are correct and neither path stalls.
REQ-042 wb_rst asserted after 4 data bits of RX and TX -> o_fsdo=1 at once, FIFO empty, and the next full frame 0x81 is received correctly.
